// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of the core's load/store port. Accepts one word-sized
//   load or store over a valid/ready request channel. Services it against an
//   internal word array with a fixed latency of LATENCY cycles. Returns load
//   data or a store acknowledgement over a valid/ready response channel.
//
// Parameters
//   DEPTH     number of 32-bit words (power of two, >= 4)
//   LATENCY   cycles from request acceptance to resp_valid (1..15)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   req_valid   request present
//   req_ready   responder can accept (decoded from registered state only)
//   req_we      1 = store, 0 = load
//   req_addr    byte address; word index is req_addr[log2(DEPTH)+1:2]
//   req_wdata   store data
//   req_wstrb   byte-lane enables for stores
//   resp_valid  response present
//   resp_ready  consumer accepts response
//   resp_rdata  load data; 0 for stores and faulted requests
//   resp_err    request faulted (misaligned, or out of range when bounded)
//
// Build option
//   DMEM_RESPONDER_BOUNDS_EN  when defined, addresses >= 4*DEPTH fault;
//                             otherwise upper address bits are ignored and
//                             addresses wrap modulo 4*DEPTH.
//
// The word array is not reset; its contents are undefined until written.

module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_fault;
  logic          w_accept;

  assign w_idx = req_addr[AW+1:2];

`ifdef DMEM_RESPONDER_BOUNDS_EN
  assign w_fault = (req_addr[1:0] != 2'b00) | (|req_addr[31:AW+2]);
`else
  // Upper address bits are deliberately ignored so addresses wrap.
  logic w_unused_upper;
  assign w_unused_upper = ^req_addr[31:AW+2];
  assign w_fault        = (req_addr[1:0] != 2'b00);
`endif

  // Reset gates acceptance: a request presented while reset is held is
  // neither accepted by the FSM nor allowed to write the array.
  assign w_accept = req_valid & r_req_ready & ~reset;

  // Array write happens at the acceptance edge; no reset so contents
  // survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            // Capture everything at acceptance; the array read returns the
            // pre-edge word, which is what a load sees.
            r_err       <= w_fault;
            r_rdata     <= (req_we || w_fault) ? '0 : r_mem[w_idx];
            r_req_ready <= 1'b0;
            if (LATENCY > 1) begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(LATENCY - 1);
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state      <= S_RESP;
            r_cnt        <= '0;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Self-checking bench for dmem_responder. A reference model holds the
//   expected word array as plain arrays (with a "known" flag per word) and
//   derives responses from address arithmetic: faults from alignment and
//   range, word index as (addr/4) mod DEPTH, store merge as a byte mask.

module tb_dmem_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int unsigned n_vec;
  int unsigned n_fail;

  logic [31:0] exp_mem   [DEPTH];
  logic        exp_known [DEPTH];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: apply one request, return the expected response.
  function automatic void model(input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [3:0] ws,
                                output logic [31:0] erd, output logic eerr,
                                output logic eknown);
    longint unsigned a;
    int unsigned     idx;
    logic [31:0]     mask;
    a    = longint'(addr);
    eerr = (a % 4) != 0;
`ifdef DMEM_RESPONDER_BOUNDS_EN
    if (a >= 4 * longint'(DEPTH)) eerr = 1'b1;
`endif
    idx    = int'((a / 4) % DEPTH);
    erd    = '0;
    eknown = 1'b1;
    if (eerr) return;
    if (we) begin
      mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
      if (ws == 4'hF) begin
        exp_mem[idx]   = wd;
        exp_known[idx] = 1'b1;
      end else if (exp_known[idx]) begin
        exp_mem[idx] = (exp_mem[idx] & ~mask) | (wd & mask);
      end
    end else begin
      erd    = exp_mem[idx];
      eknown = exp_known[idx];
    end
  endfunction

  // Drives one request and returns what was observed; checking is done by
  // the calling test.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input int unsigned hold,
                        output logic rdy0, output int unsigned lat,
                        output logic [31:0] rd, output logic er,
                        output logic stable, output logic held_low,
                        output logic rdy_after);
    @(negedge clk);
    rdy0      = req_ready;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    lat       = 0;
    rd        = '0;
    er        = 1'b0;
    stable    = 1'b1;
    held_low  = 1'b1;
    rdy_after = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 64);
    if (!resp_valid) begin
      lat = 0;
      return;
    end
    rd = resp_rdata;
    er = resp_err;
    if (req_ready !== 1'b0) held_low = 1'b0;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er) stable = 1'b0;
      if (req_ready !== 1'b0) held_low = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    rdy_after = req_ready;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    n_vec++;
    if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b vld=%b rd=%h err=%b, want 1 0 00000000 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got rdy=%b vld=%b, want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_store_load;
    logic r0, er, st, hl, ra, ee, ek;
    logic [31:0] rd, erd;
    int unsigned lat;
    model(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, ee, ek);
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (r0 !== 1'b1 || lat != LATENCY || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL store_resp: got rdy0=%b lat=%0d err=%b rd=%h, want 1 %0d 0 00000000",
               r0, lat, er, rd, LATENCY);
    end
    n_vec++;
    if (ra !== 1'b1) begin
      n_fail++;
      $display("FAIL store_ready_after: got %b want 1", ra);
    end
    model(1'b0, 32'h10, 32'h0, 4'h0, erd, ee, ek);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != LATENCY) begin
      n_fail++;
      $display("FAIL load_0x10: got rd=%h err=%b lat=%0d, want deadbeef 0 %0d", rd, er, lat, LATENCY);
    end
  endtask

  task automatic test_strobe;
    logic r0, er, st, hl, ra, ee, ek;
    logic [31:0] rd, erd;
    int unsigned lat;
    model(1'b1, 32'h20, 32'h0, 4'hF, erd, ee, ek);
    do_req(1'b1, 32'h20, 32'h0, 4'hF, 0, r0, lat, rd, er, st, hl, ra);
    model(1'b1, 32'h20, 32'h12345678, 4'b0101, erd, ee, ek);
    do_req(1'b1, 32'h20, 32'h12345678, 4'b0101, 0, r0, lat, rd, er, st, hl, ra);
    model(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, erd, ee, ek);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_strobe_resp: got err=%b rd=%h, want 0 00000000", er, rd);
    end
    model(1'b0, 32'h20, 32'h0, 4'h0, erd, ee, ek);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (rd !== 32'h00340078 || rd !== erd) begin
      n_fail++;
      $display("FAIL strobe_merge: got %h want 00340078", rd);
    end
  endtask

  task automatic test_misaligned;
    logic r0, er, st, hl, ra, ee, ek;
    logic [31:0] rd, erd;
    int unsigned lat;
    model(1'b0, 32'h13, 32'h0, 4'h0, erd, ee, ek);
    do_req(1'b0, 32'h13, 32'h0, 4'h0, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL misaligned_load: got err=%b rd=%h, want 1 00000000", er, rd);
    end
    model(1'b1, 32'h11, 32'h11111111, 4'hF, erd, ee, ek);
    do_req(1'b1, 32'h11, 32'h11111111, 4'hF, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL misaligned_store: got err=%b rd=%h, want 1 00000000", er, rd);
    end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL word_0x10_unchanged: got rd=%h err=%b, want deadbeef 0", rd, er);
    end
  endtask

  task automatic test_backpressure;
    logic r0, er, st, hl, ra;
    logic [31:0] rd;
    int unsigned lat;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (st !== 1'b1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stable: got stable=%b rd=%h err=%b, want 1 deadbeef 0", st, rd, er);
    end
    n_vec++;
    if (hl !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_low: got held_low=%b want 1", hl);
    end
    n_vec++;
    if (ra !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_after: got %b want 1", ra);
    end
  endtask

  task automatic test_reset_in_wait;
    logic r0, er, st, hl, ra;
    logic [31:0] rd;
    logic seen;
    int unsigned lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_wstrb = 4'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b vld=%b rd=%h err=%b, want 1 0 00000000 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int unsigned i = 0; i < LATENCY + 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_after_reset: got resp_valid seen=%b want 0", seen);
    end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || r0 !== 1'b1) begin
      n_fail++;
      $display("FAIL store_survives_reset: got rd=%h err=%b rdy0=%b, want deadbeef 0 1", rd, er, r0);
    end
  endtask

  task automatic test_wrap;
    logic r0, er, st, hl, ra, ee, ek;
    logic [31:0] rd, erd;
    int unsigned lat;
    model(1'b1, 32'h0, 32'hA5A50F0F, 4'hF, erd, ee, ek);
    do_req(1'b1, 32'h0, 32'hA5A50F0F, 4'hF, 0, r0, lat, rd, er, st, hl, ra);
    model(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, erd, ee, ek);
    do_req(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
`ifdef DMEM_RESPONDER_BOUNDS_EN
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL load_oob: got err=%b rd=%h, want 1 00000000", er, rd);
    end
`else
    if (er !== 1'b0 || rd !== 32'hA5A50F0F) begin
      n_fail++;
      $display("FAIL load_wrap: got err=%b rd=%h, want 0 a5a50f0f", er, rd);
    end
`endif
    model(1'b1, 32'(4 * DEPTH + 4), 32'h5A5A5A5A, 4'hF, erd, ee, ek);
    do_req(1'b1, 32'(4 * DEPTH + 4), 32'h5A5A5A5A, 4'hF, 0, r0, lat, rd, er, st, hl, ra);
    n_vec++;
    if (er !== ee) begin
      n_fail++;
      $display("FAIL store_high_err: got %b want %b", er, ee);
    end
    model(1'b0, 32'h4, 32'h0, 4'h0, erd, ee, ek);
    do_req(1'b0, 32'h4, 32'h0, 4'h0, 0, r0, lat, rd, er, st, hl, ra);
    if (ek) begin
      n_vec++;
      if (rd !== erd || er !== 1'b0) begin
        n_fail++;
        $display("FAIL word_4_after_high_store: got rd=%h err=%b, want %h 0", rd, er, erd);
      end
    end
  endtask

  task automatic test_random;
    logic r0, er, st, hl, ra, ee, ek, we;
    logic [31:0] rd, erd, addr, wd;
    logic [3:0] ws;
    int unsigned lat, hold;
    for (int unsigned i = 0; i < 16; i++) begin
      wd = $urandom;
      model(1'b1, 32'(4 * i), wd, 4'hF, erd, ee, ek);
      do_req(1'b1, 32'(4 * i), wd, 4'hF, 0, r0, lat, rd, er, st, hl, ra);
    end
    for (int unsigned n = 0; n < 60; n++) begin
      we   = 1'($urandom);
      addr = 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) addr = addr + 32'(4 * DEPTH * $urandom_range(1, 7));
      wd   = $urandom;
      ws   = 4'($urandom);
      hold = $urandom_range(0, 3);
      model(we, addr, wd, ws, erd, ee, ek);
      do_req(we, addr, wd, ws, hold, r0, lat, rd, er, st, hl, ra);
      n_vec++;
      if (r0 !== 1'b1 || lat != LATENCY || er !== ee || (ek && rd !== erd) ||
          st !== 1'b1 || hl !== 1'b1 || ra !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_%0d we=%b addr=%h: got rdy0=%b lat=%0d err=%b rd=%h st=%b hl=%b ra=%b, want 1 %0d %b %h 1 1 1",
                 n, we, addr, r0, lat, er, rd, st, hl, ra, LATENCY, ee, erd);
      end
    end
  endtask

  initial begin
    n_vec      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      exp_mem[i]   = '0;
      exp_known[i] = 1'b0;
    end
    test_reset;
    test_store_load;
    test_strobe;
    test_misaligned;
    test_backpressure;
    test_reset_in_wait;
    test_wrap;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
